// File: rtl/mem_access_sequencer.sv
// Sequences one load or store through MAR, MDR and the RAM, handling the MFC
// handshake, doubleword split into two word beats, and alignment/timeout traps.
module mem_access_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       start,
    input  logic       is_store,
    input  logic [1:0] size,
    input  logic       sign,
    input  logic [2:0] addr_lo,
    input  logic       MFC,
    output logic       MAR_Enable,
    output logic       MDR_Enable,
    output logic       MDR_Mux_select,
    output logic       RAM_enable,
    output logic [5:0] RAM_OpCode,
    output logic       mar_inc,
    output logic       rd_second,
    output logic       busy,
    output logic       done,
    output logic       align_trap,
    output logic       timeout_trap
);

    localparam int unsigned OP_W = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_ACCESS,
        S_CAPTURE,
        S_NEXT,
        S_DONE,
        S_FAULT_A,
        S_FAULT_T
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_DW   = 2'b11;

    state_t             state, state_next;
    logic               cmd_store, cmd_store_next;
    logic               cmd_sign, cmd_sign_next;
    logic [1:0]         cmd_size, cmd_size_next;
    logic               beat2, beat2_next;
    logic [CNT_W-1:0]   cnt, cnt_next;

    logic               aligned_c;
    logic               dw_first_c;
    logic [1:0]         size_eff_c;

    logic               mar_en_n, mdr_en_n, mdr_mux_n, ram_en_n;
    logic [OP_W-1:0]    opcode_n;
    logic               mar_inc_n, rd_second_n, busy_n, done_n;
    logic               align_trap_n, timeout_trap_n;

    // Alignment is judged on the live request inputs, only meaningful on start in IDLE.
    always_comb begin
        aligned_c = 1'b1;
        case (size)
            SZ_HALF: aligned_c = (addr_lo[0] == 1'b0);
            SZ_WORD: aligned_c = (addr_lo[1:0] == 2'b00);
            SZ_DW:   aligned_c = (addr_lo == 3'b000);
            default: aligned_c = 1'b1;
        endcase
    end

    assign dw_first_c = (cmd_size == SZ_DW) && !beat2;

    // Next-state, command/beat/counter update and next-cycle output decode.
    always_comb begin
        state_next     = state;
        cmd_store_next = cmd_store;
        cmd_sign_next  = cmd_sign;
        cmd_size_next  = cmd_size;
        beat2_next     = beat2;
        cnt_next       = cnt;
        mar_en_n       = 1'b0;
        mdr_en_n       = 1'b0;
        mdr_mux_n      = 1'b0;
        ram_en_n       = 1'b0;
        opcode_n       = '0;
        mar_inc_n      = 1'b0;
        rd_second_n    = 1'b0;
        busy_n         = 1'b0;
        done_n         = 1'b0;
        align_trap_n   = 1'b0;
        timeout_trap_n = 1'b0;
        size_eff_c     = SZ_BYTE;

        case (state)
            S_IDLE: begin
                if (start) begin
                    cmd_store_next = is_store;
                    cmd_sign_next  = sign;
                    cmd_size_next  = size;
                    beat2_next     = 1'b0;
                    state_next     = aligned_c ? S_ADDR : S_FAULT_A;
                end
            end
            S_ADDR:    state_next = cmd_store ? S_WDATA : S_ACCESS;
            S_WDATA:   state_next = S_ACCESS;
            S_ACCESS: begin
                if (MFC) begin
                    if (!cmd_store)     state_next = S_CAPTURE;
                    else if (dw_first_c) state_next = S_NEXT;
                    else                state_next = S_DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next = S_FAULT_T;
                end
            end
            S_CAPTURE: state_next = dw_first_c ? S_NEXT : S_DONE;
            S_NEXT:    state_next = cmd_store ? S_WDATA : S_ACCESS;
            S_DONE:    state_next = S_IDLE;
            S_FAULT_A: state_next = S_IDLE;
            S_FAULT_T: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase

        // Counter restarts on every entry to ACCESS and counts cycles spent there.
        if (state == S_ACCESS) begin
            cnt_next = cnt + CNT_W'(1);
        end
        if ((state != S_ACCESS) && (state_next == S_ACCESS)) begin
            cnt_next = '0;
        end
        if (state_next == S_NEXT) begin
            beat2_next = 1'b1;
        end

        size_eff_c = (cmd_size_next == SZ_DW) ? SZ_WORD : cmd_size_next;
        busy_n     = (state_next != S_IDLE);

        case (state_next)
            S_ADDR:    mar_en_n = 1'b1;
            S_WDATA:   mdr_en_n = 1'b1;
            S_ACCESS: begin
                ram_en_n = 1'b1;
                opcode_n = {2'b00, cmd_sign_next & ~cmd_store_next, cmd_store_next, size_eff_c};
            end
            S_CAPTURE: begin
                mdr_en_n    = 1'b1;
                mdr_mux_n   = 1'b1;
                rd_second_n = beat2_next;
            end
            S_NEXT: begin
                mar_en_n  = 1'b1;
                mar_inc_n = 1'b1;
            end
            S_DONE:    done_n         = 1'b1;
            S_FAULT_A: align_trap_n   = 1'b1;
            S_FAULT_T: timeout_trap_n = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state     <= S_IDLE;
            cmd_store <= 1'b0;
            cmd_sign  <= 1'b0;
            cmd_size  <= SZ_BYTE;
            beat2     <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            cmd_store <= cmd_store_next;
            cmd_sign  <= cmd_sign_next;
            cmd_size  <= cmd_size_next;
            beat2     <= beat2_next;
            cnt       <= cnt_next;
        end
    end

    // Outputs are registered from the decode of the next state, so they track the state register.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            MAR_Enable     <= 1'b0;
            MDR_Enable     <= 1'b0;
            MDR_Mux_select <= 1'b0;
            RAM_enable     <= 1'b0;
            RAM_OpCode     <= '0;
            mar_inc        <= 1'b0;
            rd_second      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            align_trap     <= 1'b0;
            timeout_trap   <= 1'b0;
        end else begin
            MAR_Enable     <= mar_en_n;
            MDR_Enable     <= mdr_en_n;
            MDR_Mux_select <= mdr_mux_n;
            RAM_enable     <= ram_en_n;
            RAM_OpCode     <= opcode_n;
            mar_inc        <= mar_inc_n;
            rd_second      <= rd_second_n;
            busy           <= busy_n;
            done           <= done_n;
            align_trap     <= align_trap_n;
            timeout_trap   <= timeout_trap_n;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: stimulus pushes the expected
// per-cycle output vectors, a negedge monitor pops and compares busy cycles.
module tb_mem_access_sequencer;

    logic       Clk = 1'b0;
    logic       Clr;
    logic       start, is_store, sign, MFC;
    logic [1:0] size;
    logic [2:0] addr_lo;
    logic       MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable;
    logic [5:0] RAM_OpCode;
    logic       mar_inc, rd_second, busy, done, align_trap, timeout_trap;

    int n_cmp = 0;
    int n_bad = 0;
    int mfc_wait = 0;
    bit mfc_force = 1'b0;
    int acc_k = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs;

    mem_access_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut (
        .Clk(Clk), .Clr(Clr), .start(start), .is_store(is_store), .size(size),
        .sign(sign), .addr_lo(addr_lo), .MFC(MFC), .MAR_Enable(MAR_Enable),
        .MDR_Enable(MDR_Enable), .MDR_Mux_select(MDR_Mux_select),
        .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode), .mar_inc(mar_inc),
        .rd_second(rd_second), .busy(busy), .done(done),
        .align_trap(align_trap), .timeout_trap(timeout_trap)
    );

    always #5 Clk = ~Clk;

    assign obs = {MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
                  mar_inc, rd_second, busy, done, align_trap, timeout_trap};

    // Expected vector bit order: mar mdr mux ram op[5:0] inc rd2 busy done atrap ttrap
    function automatic logic [15:0] e_addr();
        return {1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 1'b1, 3'b000};
    endfunction
    function automatic logic [15:0] e_wdata();
        return {1'b0, 1'b1, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 1'b1, 3'b000};
    endfunction
    function automatic logic [15:0] e_access(input logic [5:0] op);
        return {1'b0, 1'b0, 1'b0, 1'b1, op, 1'b0, 1'b0, 1'b1, 3'b000};
    endfunction
    function automatic logic [15:0] e_capture(input logic rd2);
        return {1'b0, 1'b1, 1'b1, 1'b0, 6'b0, 1'b0, rd2, 1'b1, 3'b000};
    endfunction
    function automatic logic [15:0] e_next();
        return {1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 1'b1, 1'b0, 1'b1, 3'b000};
    endfunction
    function automatic logic [15:0] e_end(input logic [2:0] kind);
        return {1'b0, 1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 1'b1, kind};
    endfunction

    // RAM responder: MFC rises after mfc_wait low cycles of a RAM request.
    always @(negedge Clk) begin
        if (RAM_enable) acc_k = acc_k + 1;
        else            acc_k = 0;
        MFC = mfc_force || (RAM_enable && (acc_k > mfc_wait));
    end

    // Monitor: every cycle the DUT shows activity must match the next expected vector.
    always @(negedge Clk) begin
        if (Clr === 1'b1 && obs !== 16'h0000) begin
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected_activity t=%0t got=%b required=none", $time, obs);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_bad = n_bad + 1;
                    $display("FAIL seq t=%0t got=%b required=%b", $time, obs, e);
                end
            end
        end
    end

    task automatic push_access(input logic [5:0] op, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(e_access(op));
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [2:0] a, input int w);
        @(negedge Clk); #1;
        mfc_wait = w;
        is_store = st; size = sz; sign = sg; addr_lo = a; start = 1'b1;
        @(negedge Clk); #1;
        start = 1'b0;
        is_store = ~st; size = ~sz; sign = ~sg; addr_lo = ~a;
    endtask

    task automatic check_idle(input string name);
        n_cmp = n_cmp + 1;
        if (obs !== 16'h0000) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%b required=%b", name, obs, 16'h0000);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge Clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s_drain got=%0d_pending required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge Clk);
        #1 check_idle({name, "_idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Clr = 1'b0; start = 1'b0; is_store = 1'b0; size = 2'b00; sign = 1'b0;
        addr_lo = 3'b000; MFC = 1'b0;
        repeat (3) @(negedge Clk);
        #1 check_idle("reset_state");
        Clr = 1'b1;

        // Load word, MFC held high throughout (also high outside ACCESS)
        mfc_force = 1'b1;
        exp_q.push_back(e_addr()); push_access(6'b000010, 1);
        exp_q.push_back(e_capture(1'b0)); exp_q.push_back(e_end(3'b100));
        issue(1'b0, 2'b10, 1'b0, 3'b000, 0);
        drain("load_word", 20);
        mfc_force = 1'b0;

        // Store half at 010, RAM request held three cycles
        exp_q.push_back(e_addr()); exp_q.push_back(e_wdata());
        push_access(6'b000101, 3); exp_q.push_back(e_end(3'b100));
        issue(1'b1, 2'b01, 1'b0, 3'b010, 2);
        drain("store_half", 20);

        // Load doubleword: two word beats, second capture flagged
        exp_q.push_back(e_addr()); push_access(6'b000010, 1);
        exp_q.push_back(e_capture(1'b0)); exp_q.push_back(e_next());
        push_access(6'b000010, 1); exp_q.push_back(e_capture(1'b1));
        exp_q.push_back(e_end(3'b100));
        issue(1'b0, 2'b11, 1'b0, 3'b000, 0);
        drain("load_dw", 20);

        // Store doubleword with one wait cycle per beat
        exp_q.push_back(e_addr()); exp_q.push_back(e_wdata());
        push_access(6'b000110, 2); exp_q.push_back(e_next());
        exp_q.push_back(e_wdata()); push_access(6'b000110, 2);
        exp_q.push_back(e_end(3'b100));
        issue(1'b1, 2'b11, 1'b0, 3'b000, 1);
        drain("store_dw", 30);

        // Signed half load at 110
        exp_q.push_back(e_addr()); push_access(6'b001001, 1);
        exp_q.push_back(e_capture(1'b0)); exp_q.push_back(e_end(3'b100));
        issue(1'b0, 2'b01, 1'b1, 3'b110, 0);
        drain("load_half_signed", 20);

        // Misaligned requests trap immediately with no MAR/RAM activity
        exp_q.push_back(e_end(3'b010));
        issue(1'b0, 2'b10, 1'b0, 3'b010, 0);
        drain("misaligned_word", 10);
        exp_q.push_back(e_end(3'b010));
        issue(1'b1, 2'b01, 1'b0, 3'b001, 0);
        drain("misaligned_half", 10);
        exp_q.push_back(e_end(3'b010));
        issue(1'b0, 2'b11, 1'b0, 3'b100, 0);
        drain("misaligned_dw", 10);

        // Signed byte load at odd address, MFC never comes: 16 request cycles then trap
        exp_q.push_back(e_addr()); push_access(6'b001000, 16);
        exp_q.push_back(e_end(3'b001));
        issue(1'b0, 2'b00, 1'b1, 3'b001, 1000);
        repeat (4) @(negedge Clk);
        #1 start = 1'b1; is_store = 1'b1; size = 2'b11; addr_lo = 3'b101;
        @(negedge Clk); #1 start = 1'b0;
        drain("timeout", 40);

        // Abort mid-operation with Clr, then immediate restart
        exp_q.push_back(e_addr()); push_access(6'b000010, 16);
        exp_q.push_back(e_end(3'b001));
        issue(1'b0, 2'b10, 1'b0, 3'b000, 1000);
        @(negedge Clk); #1;
        Clr = 1'b0;
        exp_q.delete();
        #1 check_idle("abort_clear");
        @(negedge Clk); #1 Clr = 1'b1;
        exp_q.push_back(e_addr()); push_access(6'b000010, 1);
        exp_q.push_back(e_capture(1'b0)); exp_q.push_back(e_end(3'b100));
        issue(1'b0, 2'b10, 1'b0, 3'b000, 0);
        drain("restart_after_clr", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
